// File: rtl/conv1_relu_pool.sv
// Six-channel requantize + ReLU + 2x2 max-pool stage for a raster-ordered conv map.
// A registered requantization stage feeds a horizontal hold register and a half-width row buffer.
module conv1_relu_pool #(
    parameter int IN_WIDTH  = 32,
    parameter int ACT_WIDTH = 8,
    parameter int SHIFT     = 8,
    parameter int MAP_W     = 24,
    parameter int MAP_H     = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 valid_in,
    input  logic [IN_WIDTH-1:0]  in_ch0,
    input  logic [IN_WIDTH-1:0]  in_ch1,
    input  logic [IN_WIDTH-1:0]  in_ch2,
    input  logic [IN_WIDTH-1:0]  in_ch3,
    input  logic [IN_WIDTH-1:0]  in_ch4,
    input  logic [IN_WIDTH-1:0]  in_ch5,
    output logic [ACT_WIDTH-1:0] out_ch0,
    output logic [ACT_WIDTH-1:0] out_ch1,
    output logic [ACT_WIDTH-1:0] out_ch2,
    output logic [ACT_WIDTH-1:0] out_ch3,
    output logic [ACT_WIDTH-1:0] out_ch4,
    output logic [ACT_WIDTH-1:0] out_ch5,
    output logic                 out_valid,
    output logic [7:0]           pool_row,
    output logic [7:0]           pool_col,
    output logic                 frame_done
);

    localparam int NCH = 6;
    localparam int CW  = $clog2(MAP_W) + 1;
    localparam int RW  = $clog2(MAP_H) + 1;
    localparam int HW  = (MAP_W > 2) ? $clog2(MAP_W / 2) : 1;

    typedef logic [NCH-1:0][ACT_WIDTH-1:0] act_vec_t;

    // ReLU then truncating shift; anything beyond the activation range saturates.
    function automatic logic [ACT_WIDTH-1:0] requant(input logic [IN_WIDTH-1:0] x);
        logic [IN_WIDTH-1:0] sh;
        sh = IN_WIDTH'($signed(x) >>> SHIFT);
        if (x[IN_WIDTH-1] || (x == {IN_WIDTH{1'b0}})) begin
            requant = {ACT_WIDTH{1'b0}};
        end else if (|sh[IN_WIDTH-1:ACT_WIDTH]) begin
            requant = {ACT_WIDTH{1'b1}};
        end else begin
            requant = sh[ACT_WIDTH-1:0];
        end
    endfunction

    logic [NCH-1:0][IN_WIDTH-1:0] in_vec;
    act_vec_t                     in_q;
    logic [CW-1:0]                col_cnt;
    logic [RW-1:0]                row_cnt;
    logic [CW-1:0]                eff_col;
    logic [RW-1:0]                eff_row;

    logic                         s1_valid;
    act_vec_t                     s1_q;
    logic [CW-1:0]                s1_col;
    logic [RW-1:0]                s1_row;

    act_vec_t                     hold;
    act_vec_t                     row_buf [MAP_W/2];
    logic [HW-1:0]                hidx;
    act_vec_t                     rb;
    act_vec_t                     hmax;
    act_vec_t                     pooled;
    act_vec_t                     out_reg;
    logic                         s1_take;

    assign in_vec  = {in_ch5, in_ch4, in_ch3, in_ch2, in_ch1, in_ch0};
    // A clear in the same cycle as a sample makes that sample pixel (0,0).
    assign eff_col = clear ? {CW{1'b0}} : col_cnt;
    assign eff_row = clear ? {RW{1'b0}} : row_cnt;
    assign hidx    = s1_col[HW:1];
    assign rb      = row_buf[hidx];
    assign s1_take = s1_valid && !clear;

    // Per-channel requantization and the two max trees.
    always_comb begin
        in_q   = {NCH*ACT_WIDTH{1'b0}};
        hmax   = {NCH*ACT_WIDTH{1'b0}};
        pooled = {NCH*ACT_WIDTH{1'b0}};
        for (int c = 0; c < NCH; c++) begin
            in_q[c]   = requant(in_vec[c]);
            hmax[c]   = (hold[c] > s1_q[c]) ? hold[c] : s1_q[c];
            pooled[c] = (rb[c] > hmax[c]) ? rb[c] : hmax[c];
        end
    end

    // Input raster counters and stage-1 register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_cnt  <= {CW{1'b0}};
            row_cnt  <= {RW{1'b0}};
            s1_valid <= 1'b0;
            s1_q     <= {NCH*ACT_WIDTH{1'b0}};
            s1_col   <= {CW{1'b0}};
            s1_row   <= {RW{1'b0}};
        end else if (valid_in) begin
            s1_valid <= 1'b1;
            s1_q     <= in_q;
            s1_col   <= eff_col;
            s1_row   <= eff_row;
            if (eff_col == CW'(MAP_W - 1)) begin
                col_cnt <= {CW{1'b0}};
                row_cnt <= (eff_row == RW'(MAP_H - 1)) ? {RW{1'b0}} : eff_row + RW'(1);
            end else begin
                col_cnt <= eff_col + CW'(1);
                row_cnt <= eff_row;
            end
        end else begin
            s1_valid <= 1'b0;
            col_cnt  <= eff_col;
            row_cnt  <= eff_row;
        end
    end

    // Hold and row-buffer storage; always written before being read within a frame.
    always_ff @(posedge clk) begin
        if (s1_take) begin
            if (!s1_col[0]) begin
                hold <= s1_q;
            end else if (!s1_row[0]) begin
                row_buf[hidx] <= hmax;
            end
        end
    end

    // Pooled output register; data and coordinates hold between pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_reg    <= {NCH*ACT_WIDTH{1'b0}};
            out_valid  <= 1'b0;
            pool_row   <= 8'd0;
            pool_col   <= 8'd0;
            frame_done <= 1'b0;
        end else if (s1_take && s1_col[0] && s1_row[0]) begin
            out_reg    <= pooled;
            out_valid  <= 1'b1;
            pool_row   <= 8'(s1_row[RW-1:1]);
            pool_col   <= 8'(s1_col[CW-1:1]);
            frame_done <= (s1_row == RW'(MAP_H - 1)) && (s1_col == CW'(MAP_W - 1));
        end else begin
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
        end
    end

    assign out_ch0 = out_reg[0];
    assign out_ch1 = out_reg[1];
    assign out_ch2 = out_reg[2];
    assign out_ch3 = out_reg[3];
    assign out_ch4 = out_reg[4];
    assign out_ch5 = out_reg[5];

endmodule

// File: tb/tb_conv1_relu_pool.sv
// Scoreboard bench: an image-level reference model predicts each pooled pixel and its cycle.
module tb_conv1_relu_pool;
    localparam int W = 24;
    localparam int H = 24;

    typedef struct {
        logic [5:0][7:0] v;
        int prow;
        int pcol;
        bit fd;
        int due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clear = 1'b0;
    logic        valid_in = 1'b0;
    logic [31:0] din [6];
    logic [7:0]  dout [6];
    logic        out_valid, frame_done;
    logic [7:0]  pool_row, pool_col;

    exp_t        sb[$];
    int          qimg [H][W][6];
    int          mrow = 0, mcol = 0;
    int          cyc = 0;
    int          checks = 0, errors = 0, pulses = 0, base = 0;
    logic [7:0]  last_v [6];
    logic [7:0]  last_r, last_c;
    logic [7:0]  ramp_seen [12];

    conv1_relu_pool dut (
        .clk(clk), .rst(rst), .clear(clear), .valid_in(valid_in),
        .in_ch0(din[0]), .in_ch1(din[1]), .in_ch2(din[2]),
        .in_ch3(din[3]), .in_ch4(din[4]), .in_ch5(din[5]),
        .out_ch0(dout[0]), .out_ch1(dout[1]), .out_ch2(dout[2]),
        .out_ch3(dout[3]), .out_ch4(dout[4]), .out_ch5(dout[5]),
        .out_valid(out_valid), .pool_row(pool_row), .pool_col(pool_col),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int quant(input logic [31:0] x);
        longint s;
        s = longint'($signed(x));
        if (s <= 0) return 0;
        s = s / 256;
        return (s > 255) ? 255 : int'(s);
    endfunction

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    task automatic model_step(input bit vin, input bit clr, input logic [5:0][31:0] v);
        exp_t e;
        if (clr) begin
            while (sb.size() > 0 && sb[$].due > cyc) void'(sb.pop_back());
            mrow = 0;
            mcol = 0;
        end
        if (vin) begin
            for (int ch = 0; ch < 6; ch++) qimg[mrow][mcol][ch] = quant(v[ch]);
            if ((mrow % 2 == 1) && (mcol % 2 == 1)) begin
                for (int ch = 0; ch < 6; ch++)
                    e.v[ch] = 8'(max4(qimg[mrow-1][mcol-1][ch], qimg[mrow-1][mcol][ch],
                                      qimg[mrow][mcol-1][ch], qimg[mrow][mcol][ch]));
                e.prow = mrow / 2;
                e.pcol = mcol / 2;
                e.fd   = (mrow == H - 1) && (mcol == W - 1);
                e.due  = cyc + 2;
                sb.push_back(e);
            end
            mcol++;
            if (mcol == W) begin
                mcol = 0;
                mrow = (mrow + 1) % H;
            end
        end
    endtask

    task automatic drive(input bit vin, input bit clr, input logic [5:0][31:0] v);
        @(posedge clk);
        #1;
        valid_in = vin;
        clear    = clr;
        for (int ch = 0; ch < 6; ch++) din[ch] = v[ch];
        model_step(vin, clr, v);
    endtask

    task automatic idle(input int n);
        logic [5:0][31:0] z;
        z = '0;
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, z);
    endtask

    // mode 0: constant cv, 1: random, 2: ramp on ch0 (others random)
    task automatic run(input int mode, input logic [31:0] cv, input int n, input int gap);
        logic [5:0][31:0] v;
        for (int i = 0; i < n; i++) begin
            for (int ch = 0; ch < 6; ch++) begin
                if (mode == 0) v[ch] = cv;
                else v[ch] = 32'($urandom_range(0, 90000)) - 32'd10000;
            end
            if (mode == 2) v[0] = 32'((mrow * W + mcol) << 8);
            drive(1'b1, 1'b0, v);
            if (gap > 0) idle($urandom_range(0, gap));
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        valid_in = 1'b0;
        clear = 1'b0;
        while (sb.size() > 0 && sb[$].due >= cyc) void'(sb.pop_back());
        mrow = 0;
        mcol = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain_check(input string name, input int want);
        idle(6);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected pulses still pending, required 0", name, sb.size());
            sb.delete();
        end
        checks++;
        if (pulses - base != want) begin
            errors++;
            $display("FAIL %s: pulse count %0d, required %0d", name, pulses - base, want);
        end
    endtask

    task automatic resync();
        logic [5:0][31:0] z;
        z = '0;
        drive(1'b0, 1'b1, z);
        idle(1);
        base = pulses;
    endtask

    // Monitor: pops and compares on each pulse; checks hold and missing pulses otherwise.
    always @(negedge clk) begin
        exp_t e;
        bit bad;
        if (rst) begin
            checks++;
            bad = out_valid !== 1'b0 || frame_done !== 1'b0 || pool_row !== 8'd0 || pool_col !== 8'd0;
            for (int ch = 0; ch < 6; ch++) if (dout[ch] !== 8'd0) bad = 1'b1;
            if (bad) begin
                errors++;
                $display("FAIL reset_state: valid=%b fd=%b row=%0d col=%0d ch0=%0d, required all 0",
                         out_valid, frame_done, pool_row, pool_col, dout[0]);
            end
            for (int ch = 0; ch < 6; ch++) last_v[ch] = 8'd0;
            last_r = 8'd0;
            last_c = 8'd0;
        end else if (out_valid === 1'b1) begin
            pulses++;
            if (pool_row == 8'd0 && pool_col < 8'd12) ramp_seen[pool_col] = dout[0];
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: at (%0d,%0d) cycle %0d, required no pulse",
                         pool_row, pool_col, cyc);
            end else begin
                e = sb.pop_front();
                bad = (pool_row !== 8'(e.prow)) || (pool_col !== 8'(e.pcol)) || (frame_done !== e.fd);
                for (int ch = 0; ch < 6; ch++) if (dout[ch] !== e.v[ch]) bad = 1'b1;
                if (bad) begin
                    errors++;
                    $display("FAIL pooled_pixel: got (%0d,%0d) fd=%b ch=%0d,%0d,%0d,%0d,%0d,%0d required (%0d,%0d) fd=%b ch=%0d,%0d,%0d,%0d,%0d,%0d",
                             pool_row, pool_col, frame_done, dout[0], dout[1], dout[2], dout[3], dout[4], dout[5],
                             e.prow, e.pcol, e.fd, e.v[0], e.v[1], e.v[2], e.v[3], e.v[4], e.v[5]);
                end
                checks++;
                if (e.due != cyc) begin
                    errors++;
                    $display("FAIL latency: pulse at cycle %0d, required cycle %0d", cyc, e.due);
                end
            end
            for (int ch = 0; ch < 6; ch++) last_v[ch] = dout[ch];
            last_r = pool_row;
            last_c = pool_col;
        end else begin
            checks++;
            bad = frame_done !== 1'b0 || pool_row !== last_r || pool_col !== last_c;
            for (int ch = 0; ch < 6; ch++) if (dout[ch] !== last_v[ch]) bad = 1'b1;
            if (bad) begin
                errors++;
                $display("FAIL hold: fd=%b row=%0d col=%0d ch0=%0d, required fd=0 row=%0d col=%0d ch0=%0d",
                         frame_done, pool_row, pool_col, dout[0], last_r, last_c, last_v[0]);
            end
            if (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_pulse: no pulse for (%0d,%0d), required at cycle %0d",
                         e.prow, e.pcol, e.due);
            end
        end
    end

    initial begin
        logic [5:0][31:0] v;
        for (int ch = 0; ch < 6; ch++) din[ch] = 32'd0;
        #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        base = pulses;

        run(0, 32'd768, W * H, 0);
        drain_check("const_768", 144);

        resync();
        run(0, -32'sd5000, W * H, 0);
        drain_check("negative_frame", 144);

        resync();
        run(0, 32'h0010_0000, W * H, 0);
        drain_check("saturate_frame", 144);

        resync();
        run(2, 32'd0, 2 * W, 0);
        drain_check("ramp_rows", 12);
        checks++;
        if (ramp_seen[0] !== 8'd25 || ramp_seen[1] !== 8'd27 || ramp_seen[11] !== 8'd47) begin
            errors++;
            $display("FAIL ramp_values: got %0d,%0d,%0d required 25,27,47",
                     ramp_seen[0], ramp_seen[1], ramp_seen[11]);
        end

        resync();
        run(0, 32'd768, W * H, 3);
        drain_check("const_768_gaps", 144);

        resync();
        run(1, 32'd0, W * H, 3);
        drain_check("random_gaps", 144);

        resync();
        run(1, 32'd0, 100, 0);
        do_reset();
        base = pulses;
        run(1, 32'd0, W * H, 1);
        drain_check("reset_midframe", 144);

        resync();
        run(1, 32'd0, 300, 0);
        for (int ch = 0; ch < 6; ch++) v[ch] = 32'd40000;
        drive(1'b1, 1'b1, v);
        @(negedge clk);
        #1;
        base = pulses;
        run(1, 32'd0, W * H - 1, 0);
        drain_check("clear_with_valid", 144);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
